// File: rtl/alu_exec_unit.sv
// Execute-stage ALU for the single-cycle MIPS core: funct decode, 32-bit ALU with
// flags and a parallel branch-target adder, all results registered behind en.
module alu_exec_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [5:0]  alu_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  input  logic [31:0] br_base,
  input  logic [31:0] br_off,
  output logic [3:0]  alu_ctl,
  output logic [31:0] alu_res,
  output logic        zero,
  output logic        ovf,
  output logic        cout,
  output logic [31:0] br_sum
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;

  typedef enum logic [CW-1:0] {
    CTL_AND  = 4'b0000,
    CTL_OR   = 4'b0001,
    CTL_ADD  = 4'b0010,
    CTL_ADDU = 4'b0011,
    CTL_XOR  = 4'b0100,
    CTL_SUB  = 4'b0110,
    CTL_SLT  = 4'b0111,
    CTL_SUBU = 4'b1000,
    CTL_NOR  = 4'b1100
  } ctl_e;

  ctl_e          ctl_c;
  logic [DW:0]   sum_add_c;
  logic [DW:0]   sum_sub_c;
  logic          ovf_add_c;
  logic          ovf_sub_c;
  logic [DW-1:0] res_c;
  logic          ovf_c;
  logic          cout_c;

  // Funct decode; unrecognised codes fall back to ADD.
  always_comb begin
    ctl_c = CTL_ADD;
    case (alu_op)
      6'h20:   ctl_c = CTL_ADD;
      6'h21:   ctl_c = CTL_ADDU;
      6'h22:   ctl_c = CTL_SUB;
      6'h23:   ctl_c = CTL_SUBU;
      6'h24:   ctl_c = CTL_AND;
      6'h25:   ctl_c = CTL_OR;
      6'h26:   ctl_c = CTL_XOR;
      6'h27:   ctl_c = CTL_NOR;
      6'h2A:   ctl_c = CTL_SLT;
      default: ctl_c = CTL_ADD;
    endcase
  end

  // Shared adders; subtraction is a + ~b + 1 so carry-out means no borrow.
  always_comb begin
    sum_add_c = {1'b0, a} + {1'b0, b} + (DW + 1)'(cin);
    sum_sub_c = {1'b0, a} + {1'b0, ~b} + (DW + 1)'(1);
    ovf_add_c = (a[DW-1] == b[DW-1]) && (sum_add_c[DW-1] != a[DW-1]);
    ovf_sub_c = (a[DW-1] != b[DW-1]) && (sum_sub_c[DW-1] != a[DW-1]);
  end

  always_comb begin
    res_c  = '0;
    ovf_c  = 1'b0;
    cout_c = 1'b0;
    case (ctl_c)
      CTL_ADD: begin
        res_c  = sum_add_c[DW-1:0];
        cout_c = sum_add_c[DW];
        ovf_c  = ovf_add_c;
      end
      CTL_ADDU: begin
        res_c  = sum_add_c[DW-1:0];
        cout_c = sum_add_c[DW];
      end
      CTL_SUB: begin
        res_c  = sum_sub_c[DW-1:0];
        cout_c = sum_sub_c[DW];
        ovf_c  = ovf_sub_c;
      end
      CTL_SUBU: begin
        res_c  = sum_sub_c[DW-1:0];
        cout_c = sum_sub_c[DW];
      end
      CTL_AND: res_c = a & b;
      CTL_OR:  res_c = a | b;
      CTL_XOR: res_c = a ^ b;
      CTL_NOR: res_c = ~(a | b);
      // Signed less-than survives overflow of a-b by flipping the sign bit.
      CTL_SLT: res_c = {{(DW - 1){1'b0}}, sum_sub_c[DW-1] ^ ovf_sub_c};
      default: res_c = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_ctl <= '0;
      alu_res <= '0;
      zero    <= 1'b0;
      ovf     <= 1'b0;
      cout    <= 1'b0;
      br_sum  <= '0;
    end else if (en) begin
      alu_ctl <= ctl_c;
      alu_res <= res_c;
      zero    <= (res_c == '0);
      ovf     <= ovf_c;
      cout    <= cout_c;
      br_sum  <= br_base + br_off;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed cases plus randomized traffic
// compared against an arithmetic reference model.
module tb_alu_exec_unit;

  logic        clk;
  logic        reset;
  logic        en;
  logic [5:0]  alu_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic [31:0] br_base;
  logic [31:0] br_off;
  logic [3:0]  alu_ctl;
  logic [31:0] alu_res;
  logic        zero;
  logic        ovf;
  logic        cout;
  logic [31:0] br_sum;

  int checks = 0;
  int failures = 0;

  logic [3:0]  e_ctl;
  logic [31:0] e_res;
  logic        e_zero;
  logic        e_ovf;
  logic        e_cout;
  logic [31:0] e_br;

  alu_exec_unit dut (
    .clk(clk), .reset(reset), .en(en), .alu_op(alu_op), .a(a), .b(b), .cin(cin),
    .br_base(br_base), .br_off(br_off), .alu_ctl(alu_ctl), .alu_res(alu_res),
    .zero(zero), .ovf(ovf), .cout(cout), .br_sum(br_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: true-integer arithmetic, overflow as a range check.
  function automatic void model(input logic [5:0] op, input logic [31:0] x, input logic [31:0] y,
                                input logic c, output logic [3:0] ctl, output logic [31:0] res,
                                output logic v, output logic co);
    longint maxs, mins, sx, sy, ux, uy, t, u;
    maxs = 64'sd2147483647;
    mins = -maxs - 64'sd1;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'd0, x});
    uy = longint'({32'd0, y});
    t = 0; u = 0; v = 1'b0; co = 1'b0; res = '0; ctl = 4'b0010;
    case (op)
      6'h21: begin
        ctl = 4'b0011; u = ux + uy + {63'd0, c}; res = u[31:0]; co = (u >>> 32) != 0;
      end
      6'h22: begin
        ctl = 4'b0110; t = sx - sy; res = t[31:0]; v = (t > maxs) || (t < mins); co = (ux >= uy);
      end
      6'h23: begin
        ctl = 4'b1000; t = ux - uy; res = t[31:0]; co = (ux >= uy);
      end
      6'h24: begin ctl = 4'b0000; res = x & y; end
      6'h25: begin ctl = 4'b0001; res = x | y; end
      6'h26: begin ctl = 4'b0100; res = x ^ y; end
      6'h27: begin ctl = 4'b1100; res = ~(x | y); end
      6'h2A: begin ctl = 4'b0111; res = (sx < sy) ? 32'd1 : 32'd0; end
      default: begin
        ctl = 4'b0010; t = sx + sy + {63'd0, c}; res = t[31:0];
        v = (t > maxs) || (t < mins);
        u = ux + uy + {63'd0, c}; co = (u >>> 32) != 0;
      end
    endcase
  endfunction

  task automatic chk(input string tag);
    checks++;
    assert (alu_ctl === e_ctl) else begin
      failures++; $error("FAIL %s alu_ctl got=%h exp=%h", tag, alu_ctl, e_ctl);
    end
    checks++;
    assert (alu_res === e_res) else begin
      failures++; $error("FAIL %s alu_res got=%h exp=%h", tag, alu_res, e_res);
    end
    checks++;
    assert (zero === e_zero) else begin
      failures++; $error("FAIL %s zero got=%b exp=%b", tag, zero, e_zero);
    end
    checks++;
    assert (ovf === e_ovf) else begin
      failures++; $error("FAIL %s ovf got=%b exp=%b", tag, ovf, e_ovf);
    end
    checks++;
    assert (cout === e_cout) else begin
      failures++; $error("FAIL %s cout got=%b exp=%b", tag, cout, e_cout);
    end
    checks++;
    assert (br_sum === e_br) else begin
      failures++; $error("FAIL %s br_sum got=%h exp=%h", tag, br_sum, e_br);
    end
  endtask

  // Hand-derived constants for the directed cases, independent of the model.
  task automatic want(input string tag, input logic [3:0] ctl, input logic [31:0] r,
                      input logic z, input logic v, input logic co);
    checks++;
    assert (alu_ctl === ctl && alu_res === r && zero === z && ovf === v && cout === co) else begin
      failures++;
      $error("FAIL %s got ctl=%h res=%h z=%b v=%b c=%b exp ctl=%h res=%h z=%b v=%b c=%b",
             tag, alu_ctl, alu_res, zero, ovf, cout, ctl, r, z, v, co);
    end
  endtask

  task automatic clear_exp();
    e_ctl = '0; e_res = '0; e_zero = 1'b0; e_ovf = 1'b0; e_cout = 1'b0; e_br = '0;
  endtask

  // Drive one operation, clock it, update expectations if captured, and check.
  task automatic step(input string tag, input logic e, input logic [5:0] op, input logic [31:0] x,
                      input logic [31:0] y, input logic c, input logic [31:0] bb,
                      input logic [31:0] bo);
    logic [3:0]  m_ctl;
    logic [31:0] m_res;
    logic        m_v, m_co;
    en = e; alu_op = op; a = x; b = y; cin = c; br_base = bb; br_off = bo;
    @(posedge clk);
    #1;
    if (e) begin
      model(op, x, y, c, m_ctl, m_res, m_v, m_co);
      e_ctl = m_ctl; e_res = m_res; e_zero = (m_res == 32'd0);
      e_ovf = m_v; e_cout = m_co; e_br = bb + bo;
    end
    chk(tag);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: pick = 32'h0000_0000;
      1: pick = 32'hFFFF_FFFF;
      2: pick = 32'h8000_0000;
      3: pick = 32'h7FFF_FFFF;
      default: pick = $urandom;
    endcase
  endfunction

  initial begin
    logic [5:0] rop;
    reset = 1'b0; en = 1'b0; alu_op = '0; a = '0; b = '0; cin = 1'b0;
    br_base = '0; br_off = '0;
    clear_exp();
    #2;
    chk("reset_low");
    #4;
    chk("reset_low_edge");
    #2 reset = 1'b1;
    step("en0_after_reset", 1'b0, 6'h20, 32'd9, 32'd9, 1'b0, 32'd4, 32'd4);
    step("pre_reset_add", 1'b1, 6'h20, 32'd10, 32'd20, 1'b0, 32'd100, 32'd4);
    want("pre_reset_add_k", 4'b0010, 32'd30, 1'b0, 1'b0, 1'b0);
    #3 reset = 1'b0;
    #1;
    clear_exp();
    chk("async_reset");
    #1 reset = 1'b1;

    step("add_5_3", 1'b1, 6'h20, 32'd5, 32'd3, 1'b0, 32'd0, 32'd0);
    want("add_5_3_k", 4'b0010, 32'd8, 1'b0, 1'b0, 1'b0);
    step("add_ovf", 1'b1, 6'h20, 32'h7FFF_FFFF, 32'd1, 1'b0, 32'd0, 32'd0);
    want("add_ovf_k", 4'b0010, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    step("addu_wrap", 1'b1, 6'h21, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 32'd0);
    want("addu_wrap_k", 4'b0011, 32'd0, 1'b1, 1'b0, 1'b1);
    step("add_cin", 1'b1, 6'h20, 32'd1, 32'd1, 1'b1, 32'd0, 32'd0);
    want("add_cin_k", 4'b0010, 32'd3, 1'b0, 1'b0, 1'b0);
    step("sub_eq", 1'b1, 6'h22, 32'h1234, 32'h1234, 1'b1, 32'd0, 32'd0);
    want("sub_eq_k", 4'b0110, 32'd0, 1'b1, 1'b0, 1'b1);
    step("sub_ovf", 1'b1, 6'h22, 32'h8000_0000, 32'd1, 1'b0, 32'd0, 32'd0);
    want("sub_ovf_k", 4'b0110, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1);
    step("subu_borrow", 1'b1, 6'h23, 32'd1, 32'd2, 1'b1, 32'd0, 32'd0);
    want("subu_borrow_k", 4'b1000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    step("slt_m1_1", 1'b1, 6'h2A, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 32'd0);
    want("slt_m1_1_k", 4'b0111, 32'd1, 1'b0, 1'b0, 1'b0);
    step("slt_1_m1", 1'b1, 6'h2A, 32'd1, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'd0);
    want("slt_1_m1_k", 4'b0111, 32'd0, 1'b1, 1'b0, 1'b0);
    step("slt_min_max", 1'b1, 6'h2A, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 32'd0, 32'd0);
    want("slt_min_max_k", 4'b0111, 32'd1, 1'b0, 1'b0, 1'b0);
    step("and", 1'b1, 6'h24, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, 32'd0, 32'd0);
    want("and_k", 4'b0000, 32'hF000_F000, 1'b0, 1'b0, 1'b0);
    step("or", 1'b1, 6'h25, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, 32'd0, 32'd0);
    want("or_k", 4'b0001, 32'hFFF0_FFF0, 1'b0, 1'b0, 1'b0);
    step("xor", 1'b1, 6'h26, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, 32'd0, 32'd0);
    want("xor_k", 4'b0100, 32'h0FF0_0FF0, 1'b0, 1'b0, 1'b0);
    step("nor", 1'b1, 6'h27, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, 32'd0, 32'd0);
    want("nor_k", 4'b1100, 32'h000F_000F, 1'b0, 1'b0, 1'b0);
    step("unknown_op", 1'b1, 6'h3F, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 32'd0, 32'd0);
    want("unknown_op_k", 4'b0010, 32'hEFF1_EFF0, 1'b0, 1'b0, 1'b1);
    step("branch", 1'b1, 6'h20, 32'd2, 32'd2, 1'b0, 32'h0040_0004, 32'hFFFF_FFF8);
    checks++;
    assert (br_sum === 32'h003F_FFFC) else begin
      failures++; $error("FAIL branch_k br_sum got=%h exp=%h", br_sum, 32'h003F_FFFC);
    end

    for (int i = 0; i < 3; i++)
      step("hold_en0", 1'b0, 6'h22, $urandom, $urandom, 1'b1, $urandom, $urandom);
    step("resume_en1", 1'b1, 6'h26, 32'h1111_0000, 32'h0000_2222, 1'b0, 32'd8, 32'd8);
    want("resume_en1_k", 4'b0100, 32'h1111_2222, 1'b0, 1'b0, 1'b0);
    a = 32'hDEAD_BEEF; alu_op = 6'h21;
    #3;
    chk("midcycle_change");

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0: rop = 6'h20;
        1: rop = 6'h21;
        2: rop = 6'h22;
        3: rop = 6'h23;
        4: rop = 6'h24;
        5: rop = 6'h25;
        6: rop = 6'h26;
        7: rop = 6'h27;
        8: rop = 6'h2A;
        default: rop = 6'($urandom);
      endcase
      step("random", ($urandom_range(0, 7) != 0), rop, pick(), pick(), 1'($urandom),
           $urandom, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
